// File: rtl/if_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// if_fetch_unit_if
// Bundles the fetch stage's bus signals: the stall vector, the ID branch bus,
// the instruction SRAM read port and the IF->ID outputs.
//   stall           : stall vector, bit0 = PC/fetch hold, bit1 = ID hold
//   br_bus          : {br_e, br_addr[31:0]} from ID
//   inst_sram_*     : instruction SRAM request / synchronous read data
//   if_to_id_bus    : {ce, pc} handed to ID
//   id_inst         : instruction for the PC that ID currently holds
// master = fetch unit, slave = surrounding pipeline / SRAM.
// ----------------------------------------------------------------------------
interface if_fetch_unit_if #(
    parameter int unsigned STALL_W = 6
);
    logic [STALL_W-1:0] stall;
    logic [32:0]        br_bus;
    logic [31:0]        inst_sram_rdata;
    logic               inst_sram_en;
    logic [3:0]         inst_sram_wen;
    logic [31:0]        inst_sram_addr;
    logic [31:0]        inst_sram_wdata;
    logic [32:0]        if_to_id_bus;
    logic [31:0]        id_inst;

    modport master (
        input  stall,
        input  br_bus,
        input  inst_sram_rdata,
        output inst_sram_en,
        output inst_sram_wen,
        output inst_sram_addr,
        output inst_sram_wdata,
        output if_to_id_bus,
        output id_inst
    );

    modport slave (
        output stall,
        output br_bus,
        output inst_sram_rdata,
        input  inst_sram_en,
        input  inst_sram_wen,
        input  inst_sram_addr,
        input  inst_sram_wdata,
        input  if_to_id_bus,
        input  id_inst
    );
endinterface

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage: owns the PC, issues instruction SRAM reads and
// produces the IF->ID bus. Branches from ID redirect the PC; a branch seen
// while fetch is stalled is remembered and taken on release. The fetched
// instruction is frozen while ID is stalled.
//   clk : clock, rising edge
//   rst : synchronous active-low reset
//   bus : if_fetch_unit_if master modport (stall, br_bus, SRAM port,
//         if_to_id_bus, id_inst)
// ----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC,
    parameter int unsigned STALL_W  = 6
) (
    input  logic           clk,
    input  logic           rst,
    if_fetch_unit_if.master bus
);

    typedef enum logic {
        PASS = 1'b0,
        HOLD = 1'b1
    } inst_state_t;

    inst_state_t state;

    logic [31:0] pc_reg;
    logic        ce_reg;
    logic        pend_valid;
    logic [31:0] pend_addr;
    logic        ce_d;
    logic [31:0] hold_reg;

    logic        br_e;
    logic [31:0] br_addr;
    logic        stall_pc;
    logic        stall_id;
    logic [31:0] next_pc;
    logic [31:0] pass_inst;
    logic        unused_stall;

    assign br_e     = bus.br_bus[32];
    assign br_addr  = bus.br_bus[31:0];
    assign stall_pc = bus.stall[0];
    assign stall_id = bus.stall[1];

    // Upper stall bits belong to later stages; an ID bubble (bit2) needs no
    // special handling here.
    assign unused_stall = ^bus.stall;

    // Live branch beats a remembered one; the sequential path is the fallback.
    always_comb begin
        next_pc = pc_reg + 32'd4;
        if (br_e) begin
            next_pc = br_addr;
        end else if (pend_valid) begin
            next_pc = pend_addr;
        end
    end

    // SRAM data is only meaningful once a fetch was issued the cycle before.
    assign pass_inst = ce_d ? bus.inst_sram_rdata : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_reg     <= RESET_PC;
            ce_reg     <= 1'b0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            ce_d       <= 1'b0;
            hold_reg   <= '0;
            state      <= PASS;
        end else begin
            ce_d <= ce_reg;

            if (!stall_pc) begin
                pc_reg     <= next_pc;
                ce_reg     <= 1'b1;
                pend_valid <= 1'b0;
            end else if (br_e) begin
                // Last branch seen during the stall wins.
                pend_addr  <= br_addr;
                pend_valid <= 1'b1;
            end

            case (state)
                PASS: begin
                    if (stall_id) begin
                        hold_reg <= pass_inst;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stall_id) begin
                        state <= PASS;
                    end
                end
                default: state <= PASS;
            endcase
        end
    end

    assign bus.inst_sram_en    = ce_reg;
    assign bus.inst_sram_wen   = '0;
    assign bus.inst_sram_addr  = pc_reg;
    assign bus.inst_sram_wdata = '0;
    assign bus.if_to_id_bus    = {ce_reg, pc_reg};
    assign bus.id_inst         = (state == HOLD) ? hold_reg : pass_inst;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed bench for if_fetch_unit. A synchronous SRAM model returns
// inst(a) = a ^ 32'h1234_5678 one cycle after address a is presented.
// ----------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'hBFBF_FFFC;
    localparam logic [31:0] KEY      = 32'h1234_5678;

    logic clk;
    logic rst;

    int unsigned n_assert;
    int unsigned n_fail;

    if_fetch_unit_if #(.STALL_W(6)) bus ();

    if_fetch_unit #(
        .RESET_PC(RESET_PC),
        .STALL_W (6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.inst_sram_rdata <= bus.inst_sram_addr ^ KEY;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_pc(input string tag, input logic ce, input logic [31:0] pc);
        chk(tag, {31'b0, bus.if_to_id_bus}, {31'b0, ce, pc});
    endtask

    initial begin
        n_assert            = 0;
        n_fail              = 0;
        rst                 = 1'b0;
        bus.stall           = '0;
        bus.br_bus          = '0;
        bus.inst_sram_rdata = '0;

        // 1. Reset held for three edges, then two fetch advances.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_en", {63'b0, bus.inst_sram_en}, 64'd0);
            chk_pc("rst_bus", 1'b0, RESET_PC);
            chk("rst_inst", {32'b0, bus.id_inst}, 64'd0);
        end
        chk("tie_wen", {60'b0, bus.inst_sram_wen}, 64'd0);
        chk("tie_wdata", {32'b0, bus.inst_sram_wdata}, 64'd0);
        rst = 1'b1;
        tick();
        chk_pc("fetch1", 1'b1, 32'hBFC0_0000);
        chk("fetch1_en", {63'b0, bus.inst_sram_en}, 64'd1);
        chk("fetch1_inst", {32'b0, bus.id_inst}, 64'd0);
        tick();
        chk_pc("fetch2", 1'b1, 32'hBFC0_0004);
        chk("fetch2_inst", {32'b0, bus.id_inst}, {32'b0, 32'hADF4_5678});
        tick();
        chk_pc("fetch3", 1'b1, 32'hBFC0_0008);
        chk("fetch3_inst", {32'b0, bus.id_inst}, {32'b0, 32'hADF4_567C});

        // 2. Fetch+ID stall for two edges; ID keeps inst(BFC0_0004) and then
        //    advances to inst(BFC0_0008).
        bus.stall = 6'b000011;
        tick();
        chk_pc("stall_a", 1'b1, 32'hBFC0_0008);
        chk("stall_a_inst", {32'b0, bus.id_inst}, {32'b0, 32'hADF4_567C});
        tick();
        chk_pc("stall_b", 1'b1, 32'hBFC0_0008);
        chk("stall_b_inst", {32'b0, bus.id_inst}, {32'b0, 32'hADF4_567C});
        bus.stall = '0;
        tick();
        chk_pc("stall_rel", 1'b1, 32'hBFC0_000C);
        chk("stall_rel_inst", {32'b0, bus.id_inst}, {32'b0, 32'hADF4_5670});

        // 3. Unstalled branch; the delay slot is still fetched.
        tick();
        chk_pc("pre_br", 1'b1, 32'hBFC0_0010);
        bus.br_bus = {1'b1, 32'hBFC0_0100};
        tick();
        chk_pc("br_tgt", 1'b1, 32'hBFC0_0100);
        chk("br_slot_inst", {32'b0, bus.id_inst}, {32'b0, 32'hADF4_5668});
        bus.br_bus = '0;
        tick();
        chk_pc("br_next", 1'b1, 32'hBFC0_0104);
        chk("br_tgt_inst", {32'b0, bus.id_inst}, {32'b0, 32'hADF4_5778});

        // 4a. Branch in first stalled cycle only.
        bus.stall  = 6'b000001;
        bus.br_bus = {1'b1, 32'hBFC0_0200};
        tick();
        chk_pc("pend_s1", 1'b1, 32'hBFC0_0104);
        chk("pend_v1", {63'b0, dut.pend_valid}, 64'd1);
        bus.br_bus = '0;
        tick();
        chk_pc("pend_s2", 1'b1, 32'hBFC0_0104);
        tick();
        chk_pc("pend_s3", 1'b1, 32'hBFC0_0104);
        bus.stall = '0;
        tick();
        chk_pc("pend_rel", 1'b1, 32'hBFC0_0200);
        chk("pend_clr", {63'b0, dut.pend_valid}, 64'd0);

        // 4b. Two branches during one stall: the later one wins.
        bus.stall  = 6'b000001;
        bus.br_bus = {1'b1, 32'hBFC0_0280};
        tick();
        bus.br_bus = '0;
        tick();
        bus.br_bus = {1'b1, 32'hBFC0_0300};
        tick();
        chk_pc("pend2_hold", 1'b1, 32'hBFC0_0200);
        bus.br_bus = '0;
        bus.stall  = '0;
        tick();
        chk_pc("pend2_rel", 1'b1, 32'hBFC0_0300);
        chk("pend2_clr", {63'b0, dut.pend_valid}, 64'd0);

        // 4c. Live branch on the release cycle beats the pending one.
        bus.stall  = 6'b000001;
        bus.br_bus = {1'b1, 32'hBFC0_0400};
        tick();
        bus.stall  = '0;
        bus.br_bus = {1'b1, 32'hBFC0_0500};
        tick();
        chk_pc("live_wins", 1'b1, 32'hBFC0_0500);
        chk("live_clr", {63'b0, dut.pend_valid}, 64'd0);

        // 5. Wrap-around past the top of the address space.
        bus.br_bus = {1'b1, 32'hFFFF_FFFC};
        tick();
        chk_pc("wrap_top", 1'b1, 32'hFFFF_FFFC);
        bus.br_bus = '0;
        tick();
        chk_pc("wrap_zero", 1'b1, 32'h0000_0000);
        chk("wrap_inst", {32'b0, bus.id_inst}, {32'b0, 32'hEDCB_A984});

        // 6. Reset while in HOLD with a pending branch.
        bus.stall  = 6'b000011;
        bus.br_bus = {1'b1, 32'hBFC0_0600};
        tick();
        chk("hold_state", {63'b0, dut.state}, 64'd1);
        chk("hold_pend", {63'b0, dut.pend_valid}, 64'd1);
        chk("hold_inst", {32'b0, bus.id_inst}, {32'b0, 32'hEDCB_A984});
        bus.br_bus = '0;
        rst        = 1'b0;
        tick();
        chk("rh_state", {63'b0, dut.state}, 64'd0);
        chk("rh_inst", {32'b0, bus.id_inst}, 64'd0);
        chk("rh_pend", {63'b0, dut.pend_valid}, 64'd0);
        chk_pc("rh_bus", 1'b0, RESET_PC);
        chk("rh_en", {63'b0, bus.inst_sram_en}, 64'd0);
        rst       = 1'b1;
        bus.stall = '0;
        tick();
        chk_pc("rh_restart", 1'b1, 32'hBFC0_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
